// File: rtl/div_ctrl_pkg.sv
// Shared types and default sizing for the divided-clock tick controller.
// No logic; constants and the controller state encoding only.
// No flow control of its own.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam int          DEF_CNT_W     = 25;
  localparam int unsigned DEF_DIV_RESET = 25000000;
  localparam int          DEF_TCNT_W    = 16;

endpackage

// File: rtl/div_tick_counter.sv
// Divide counter with clear/enable, divide-ratio register and terminal-count decode.
// tc is combinational from registered cnt/div_reg; loads take effect next cycle.
// No handshake; the parent decides when to clear, count and load.
module div_tick_counter
  import div_ctrl_pkg::*;
#(
  parameter int          CNT_W     = DEF_CNT_W,
  parameter int unsigned DIV_RESET = DEF_DIV_RESET
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] div_reg,
  output logic             tc
);

  // div_reg is never 0, so div_reg-1 cannot wrap.
  assign tc = (cnt == div_reg - CNT_W'(1));

  // Count 0..div_reg-1 while enabled; held at zero when cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || (en && tc)) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Divide ratio register, reloaded only when the controller allows it.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= CNT_W'(DIV_RESET);
    end else if (load) begin
      div_reg <= load_div;
    end
  end

endmodule

// File: rtl/div_tick_ctrl.sv
// Start/stop controller for a programmable tick (clock-enable) with glitch-free ratio changes.
// First tick D cycles after start is sampled; outputs are decoded from registers only.
// cfg_ready drops while a ratio change waits for the next tick boundary.
module div_tick_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int          CNT_W     = DEF_CNT_W,
  parameter int unsigned DIV_RESET = DEF_DIV_RESET,
  parameter int          TCNT_W    = DEF_TCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              cfg_valid,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic              tick,
  output logic              div_clk,
  output logic              running,
  output logic [TCNT_W-1:0] tick_cnt
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  div_reg;
  logic [CNT_W-1:0]  pend_div;
  logic              pend_valid;
  logic              tc;
  logic              xfer;
  logic              cfg_zero;
  logic              end_run;
  logic              load;
  logic [CNT_W-1:0]  load_div;
  logic              clr;

  assign running   = (state != IDLE);
  assign tick      = running && tc;
  assign end_run   = tick && (state == STOPPING);
  assign cfg_ready = !rst && !pend_valid;
  assign xfer      = cfg_valid && cfg_ready;
  assign cfg_zero  = (cfg_div == '0);
  assign clr       = (state == IDLE) || (tick && pend_valid);

  div_tick_counter #(
    .CNT_W     (CNT_W),
    .DIV_RESET (DIV_RESET)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .en       (running),
    .load     (load),
    .load_div (load_div),
    .cnt      (cnt),
    .div_reg  (div_reg),
    .tc       (tc)
  );

  // Ratio load select: a pending value lands on a tick; a fresh value lands
  // directly when idle, or on the final tick of a stop (otherwise it would be
  // parked in the pending slot with no tick left to release it).
  always_comb begin
    load     = 1'b0;
    load_div = pend_div;
    if (tick && pend_valid) begin
      load = 1'b1;
    end else if (xfer && !cfg_zero && ((state == IDLE) || end_run)) begin
      load     = 1'b1;
      load_div = cfg_div;
    end
  end

  // Next-state decode; stop has priority over start in RUN simply because start is not looked at there.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = RUN;
      RUN:      if (stop)  state_nxt = STOPPING;
      STOPPING: if (tc)    state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Pending ratio holds a change accepted mid-run until the next tick boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_div   <= '0;
    end else if (tick && pend_valid) begin
      pend_valid <= 1'b0;
    end else if (xfer && !cfg_zero && (state != IDLE) && !end_run) begin
      pend_valid <= 1'b1;
      pend_div   <= cfg_div;
    end
  end

  // Divided clock toggles after each running tick and is parked low when the run ends.
  always_ff @(posedge clk) begin
    if (rst)          div_clk <= 1'b0;
    else if (end_run) div_clk <= 1'b0;
    else if (tick)    div_clk <= !div_clk;
  end

  // Tick counter restarts on start and free-wraps on every tick.
  always_ff @(posedge clk) begin
    if (rst)                         tick_cnt <= '0;
    else if (state == IDLE && start) tick_cnt <= '0;
    else if (tick)                   tick_cnt <= tick_cnt + TCNT_W'(1);
  end

  // Zero-ratio request is consumed and flagged for one cycle.
  always_ff @(posedge clk) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= xfer && cfg_zero;
  end

endmodule

// File: tb/tb_div_tick_ctrl.sv
// Scoreboard bench: an event-level model predicts absolute tick cycles, a monitor checks them.
module tb_div_tick_ctrl;

  localparam int CNT_W   = 8;
  localparam int TCNT_W  = 4;
  localparam int DIV_RST = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic              cfg_ready;
  logic              cfg_err;
  logic              tick;
  logic              div_clk;
  logic              running;
  logic [TCNT_W-1:0] tick_cnt;

  always #5 clk = ~clk;

  div_tick_ctrl #(
    .CNT_W     (CNT_W),
    .DIV_RESET (DIV_RST),
    .TCNT_W    (TCNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .div_clk   (div_clk),
    .running   (running),
    .tick_cnt  (tick_cnt)
  );

  typedef struct {
    int cyc;
    int tcnt;
    bit dclk;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: the next tick is simply "last event cycle + D".
  bit m_act = 0, m_stp = 0, m_pv = 0, m_dclk = 0, m_err = 0;
  int m_d = DIV_RST, m_pend = 0, m_next = 0, m_tcnt = 0;
  int m_c;
  bit m_was_act, m_was_stp, m_tk, m_xfer;

  task automatic schedule(int at);
    exp_t e;
    m_next = at;
    e.cyc  = at;
    e.tcnt = m_tcnt;
    e.dclk = m_dclk;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    m_c = cyc;
    if (rst) begin
      m_act = 0; m_stp = 0; m_pv = 0; m_dclk = 0; m_err = 0;
      m_d = DIV_RST; m_tcnt = 0;
      sb.delete();
    end else begin
      m_was_act = m_act;
      m_was_stp = m_stp;
      m_tk      = m_was_act && (m_c == m_next);
      m_xfer    = cfg_valid && !m_pv;
      m_err     = m_xfer && (cfg_div == 0);
      if (m_tk) begin
        m_tcnt = (m_tcnt + 1) % (1 << TCNT_W);
        if (m_pv) begin
          m_d  = m_pend;
          m_pv = 0;
        end
        if (m_was_stp) begin
          m_act = 0; m_stp = 0; m_dclk = 0;
        end else begin
          m_dclk = !m_dclk;
          schedule(m_c + m_d);
        end
      end
      if (m_xfer && cfg_div != 0) begin
        if (!m_was_act || (m_was_stp && m_tk)) m_d = int'(cfg_div);
        else begin
          m_pend = int'(cfg_div);
          m_pv   = 1;
        end
      end
      if (!m_was_act && start) begin
        m_act  = 1;
        m_tcnt = 0;
        schedule(m_c + m_d);
      end
      if (m_was_act && !m_was_stp && stop) m_stp = 1;
    end
    cyc = cyc + 1;
  end

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the model and tick scoreboard.
  always @(negedge clk) begin
    bit exp_tick;
    exp_tick = (sb.size() > 0) && (sb[0].cyc == cyc);
    chk("tick", int'(tick), int'(exp_tick));
    if (exp_tick) begin
      chk("tick_cnt_at_tick", int'(tick_cnt), sb[0].tcnt);
      chk("div_clk_at_tick", int'(div_clk), int'(sb[0].dclk));
      void'(sb.pop_front());
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      void'(sb.pop_front());
    end
    chk("running", int'(running), int'(m_act));
    chk("cfg_ready", int'(cfg_ready), int'(!rst && !m_pv));
    chk("cfg_err", int'(cfg_err), int'(m_err));
    chk("div_clk", int'(div_clk), int'(m_dclk));
    chk("tick_cnt", int'(tick_cnt), m_tcnt);
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(1); stop = 1'b0;
  endtask

  task automatic send_cfg(int v);
    bit ok;
    int w;
    ok = 0;
    w  = 0;
    cfg_valid = 1'b1;
    cfg_div   = CNT_W'(v);
    do begin
      ok = cfg_ready;
      step(1);
      w++;
    end while (!ok && w < 100);
    cfg_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL cfg_handshake got=timeout expected=accept value=%0d", v);
    end
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step(2);
    // default ratio: ticks at k+4, k+8, k+12
    pulse_start(); step(14);
    // ratio change mid-run lands on the next tick
    step(1); send_cfg(6); step(20);
    pulse_stop(); step(10);
    // zero ratio is rejected, ratio unchanged
    send_cfg(0); step(2);
    pulse_start(); step(14);
    pulse_stop(); step(10);
    // D=5, stop mid-period, start while stopping is ignored
    send_cfg(5); pulse_start(); step(7);
    pulse_stop(); step(1); pulse_start(); step(10);
    // D=1: tick every cycle, tick_cnt wraps
    send_cfg(1); pulse_start(); step(20);
    pulse_stop(); step(4);
    // reset with a pending ratio drops it
    send_cfg(3); pulse_start(); step(4);
    send_cfg(9);
    rst = 1'b1; step(1); rst = 1'b0;
    step(1); pulse_start(); step(12);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 15) == 0);
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_div   = CNT_W'($urandom_range(0, 7));
      step(1);
    end
    rst = 1'b0; start = 1'b0; cfg_valid = 1'b0;
    stop = 1'b1; step(1); stop = 1'b0;
    step(30);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_tick_ctrl.md
# div_tick_ctrl

Programmable clock-enable controller that sequences the design's divided-clock datapath: it owns the divide counter, starts and stops it on command, and accepts run-time divide-ratio changes through a valid/ready handshake. Changes apply only at a tick boundary, so the divided output never produces a runt period. It sits between the fast `clk` domain logic and every consumer of the slow clock (flops now clocked by the 1 Hz divider output), and those consumers move to `tick` as a clock enable.

## Interface
- `CNT_W`, 25: divide counter width.
- `DIV_RESET`, 25000000: divide ratio loaded at reset; 1 ≤ DIV_RESET < 2^CNT_W.
- `TCNT_W`, 16: width of tick counter.

- `clk`  in  1  single clock; everything is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse; begin ticking (honoured in IDLE only).
- `stop`  in  1  pulse; graceful stop at next tick (honoured in RUN only).
- `cfg_valid`  in  1  new divide ratio offered.
- `cfg_div`  in  CNT_W  divide ratio D; 0 is illegal.
- `cfg_ready`  out  1  controller can accept config.
- `cfg_err`  out  1  one-cycle pulse: accepted config had D=0, discarded.
- `tick`  out  1  one-cycle clock-enable strobe every D cycles.
- `div_clk`  out  1  50% (even D) square wave, toggles after each tick.
- `running`  out  1  high in RUN and STOPPING.
- `tick_cnt`  out  TCNT_W  ticks since last start, wraps.

## Operation
- States: IDLE, RUN, STOPPING.
- IDLE: counter held at 0, `tick`=0. `start`=1 leads to RUN next cycle, `tick_cnt`<=0, `cnt`<=0. `stop` is ignored.
- RUN: `cnt` increments. In the cycle where `cnt`==D-1, `tick`=1 and `cnt`<=0. `start` is ignored. `stop`=1 leads to STOPPING. If `start` and `stop` are both high, `stop` wins.
- STOPPING: counting continues. On the tick cycle, `tick`=1 and the state goes to IDLE, `cnt`<=0, `div_clk`<=0 (forced, not toggled).
- `div_clk` toggles at the end of every tick cycle in RUN.
- `tick_cnt` increments at the end of every tick cycle (RUN and STOPPING) and wraps 2^TCNT_W-1 to 0.
- Config handshake: a transfer occurs in a cycle with `cfg_valid`&&`cfg_ready`.
  - `cfg_ready` = !`rst` && !`pend_valid`.
  - IDLE transfer: `div_reg`<=`cfg_div` next cycle.
  - RUN/STOPPING transfer: value goes to `pend_div`, `pend_valid`=1, so `cfg_ready` drops. At the end of the next tick cycle, `div_reg`<=`pend_div`, `pend_valid`<=0, `cnt`<=0.
  - A pending value is also applied on the STOPPING→IDLE edge.
  - Transfer with `cfg_div`==0: handshake completes, `cfg_err`=1 the next cycle, no state change.
- D=1: `tick` is high every cycle and `div_clk` toggles every cycle.
- All arithmetic is unsigned CNT_W. The comparison is `cnt`==`div_reg`-1, and `div_reg` is never 0.

## Timing
- Reset values (cycle after `rst` sampled high):
  - state IDLE, `cnt`=0, `div_reg`=DIV_RESET, `pend_valid`=0.
  - `tick`=0, `div_clk`=0, `running`=0, `tick_cnt`=0, `cfg_err`=0.
  - `cfg_ready`=0 while `rst` is high.
- `rst` mid-operation discards the pending config and the ratio returns to DIV_RESET.
- `start` sampled in cycle k: `running`=1 from k+1, first `tick` in cycle k+D, `div_clk` rises at k+D+1, then a tick every D cycles.
- `tick` and `running` are decoded from registered state and `cnt` only; no input-to-output combinational path.
- `cfg_ready` is a function of `rst` and `pend_valid` only; it does not depend on `cfg_valid`.
- Config accepted in RUN one cycle before a tick: it is applied at the end of that tick. The following period is the new D.
- `stop` in a tick cycle: the transition to STOPPING occurs, but that tick does not end the run. The run ends on the next tick.

## Structure
- Package `div_ctrl_pkg`: state enum (IDLE, RUN, STOPPING) and the default width constants.
- Sub-module `div_tick_counter`: counter with load-zero, enable and terminal-count decode, plus `div_reg`. The FSM, handshake, pending register, `div_clk` and `tick_cnt` live in `div_tick_ctrl`.

## Test plan
- Reset then `start`, with DIV_RESET overridden to 4: `tick` at k+4, k+8, k+12; `div_clk` high in k+5..k+8; `tick_cnt`=3 after k+12.
- In RUN with D=4, send `cfg_div`=6 at cnt=1: `cfg_ready` low until the tick. Next period is 4, then ticks every 6 cycles.
- `cfg_div`=0 in IDLE: handshake completes, `cfg_err` pulses once, D unchanged (next run still ticks every 4).
- D=5, `stop` at cnt=2 with `div_clk`=1: one more tick, then `running`=0 and `div_clk`=0. A `start` during STOPPING is ignored.
- D=1, TCNT_W=4: `tick` is constant high, `div_clk` toggles each cycle, `tick_cnt` wraps 15→0 after 16 cycles.
- Assert `rst` for one cycle mid-RUN with a pending `cfg_div`=9: all outputs take reset values, the pending value is lost, and a restart ticks at DIV_RESET.
